// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants bursts of up to BURST bytes from one of four
// requesters into a downstream byte FIFO, stalling while the FIFO is full.
module fifo_wr_arbiter #(
  parameter int N_REQ = 4,
  parameter int BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic               fifo_full,
  output logic [N_REQ-1:0]   gnt,
  output logic               fifo_wen,
  output logic [7:0]         fifo_wdata,
  output logic [1:0]         owner,
  output logic               busy
);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t     state;
  logic [1:0] rr_ptr;
  logic [3:0] beat_cnt;
  logic [1:0] pick;
  logic       pick_vld;
  logic       accept;
  logic       last_beat;

  // Scan from the highest offset down so the requester closest to rr_ptr wins.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    pick     = rr_ptr;
    pick_vld = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[rr_ptr + 2'(k)]) begin
        pick     = rr_ptr + 2'(k);
        pick_vld = 1'b1;
      end
    end
  end

  assign accept    = (state == S_BURST) && req[owner] && !fifo_full;
  assign last_beat = (beat_cnt == 4'(BURST - 1));

  always_comb begin
    gnt        = '0;
    gnt[owner] = accept;
  end

  assign fifo_wen   = accept;
  assign fifo_wdata = (state == S_BURST) ? req_data[{owner, 3'b000} +: 8] : 8'h00;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      rr_ptr   <= 2'd0;
      owner    <= 2'd0;
      beat_cnt <= 4'd0;
      busy     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_vld && !fifo_full) begin
            owner    <= pick;
            beat_cnt <= 4'd0;
            state    <= S_BURST;
            busy     <= 1'b1;
          end
        end
        S_BURST: begin
          // A full FIFO freezes the burst entirely, even if the owner drops req.
          if (!fifo_full) begin
            if (accept) begin
              beat_cnt <= beat_cnt + 4'd1;
            end
            if (!req[owner] || last_beat) begin
              state  <= S_IDLE;
              busy   <= 1'b0;
              rr_ptr <= owner + 2'd1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
